wb_commit_stage: RTL

- Parametrised successor of the writeback pipeline register; the last stage of the 5-stage core.
- Latches the MEM-stage result, writes the register file and drives the debug trace.
- Unlike the previous generation, it owns exception/ertn commit:
  - priority-encodes an N-bit exception vector;
  - runs a request/acknowledge handshake with the CSR unit;
  - stalls until the CSR unit acknowledges, then issues a one-cycle pipeline flush.

---
 rtl/wb_commit_stage_pkg.sv | 19 +
 rtl/wb_commit_stage_if.sv | 56 +++++
 rtl/wb_commit_stage_exc_prio_enc.sv | 21 ++
 rtl/wb_commit_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared types for the writeback/commit stage: FSM states and exception source bit positions.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } wb_state_e;

    // Exception source positions for the default 7-source vector; higher bit wins.
    localparam int unsigned EXC_ALE  = 6;
    localparam int unsigned EXC_ADEF = 5;
    localparam int unsigned EXC_INE  = 4;
    localparam int unsigned EXC_SYS  = 3;
    localparam int unsigned EXC_BRK  = 2;
    localparam int unsigned EXC_INT  = 1;
    localparam int unsigned EXC_RSV  = 0;

endpackage

// File: rtl/wb_commit_stage_if.sv
// MEM->WB payload, register-file write, CSR commit handshake and debug trace bundle.
interface wb_commit_stage_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned EXC_W  = 7,
    parameter int unsigned IDX_W  = 3
);
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic [PC_W-1:0]   ms_pc;
    logic              ms_rf_we;
    logic [ADDR_W-1:0] ms_rf_waddr;
    logic [DATA_W-1:0] ms_rf_wdata;
    logic [EXC_W-1:0]  ms_exc_vec;
    logic              ms_ertn;
    logic [PC_W-1:0]   ms_badv;

    logic              ws_rf_we;
    logic [ADDR_W-1:0] ws_rf_waddr;
    logic [DATA_W-1:0] ws_rf_wdata;

    logic              csr_commit_req;
    logic              csr_commit_is_ertn;
    logic [IDX_W-1:0]  csr_commit_idx;
    logic [PC_W-1:0]   csr_commit_pc;
    logic [PC_W-1:0]   csr_commit_badv;
    logic              csr_commit_ack;
    logic              ws_flush;

    logic [PC_W-1:0]   debug_wb_pc;
    logic [3:0]        debug_wb_rf_we;
    logic [ADDR_W-1:0] debug_wb_rf_wnum;
    logic [DATA_W-1:0] debug_wb_rf_wdata;

    // Writeback stage side.
    modport master (
        input  ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
        input  ms_exc_vec, ms_ertn, ms_badv, csr_commit_ack,
        output ws_allowin, ws_rf_we, ws_rf_waddr, ws_rf_wdata,
        output csr_commit_req, csr_commit_is_ertn, csr_commit_idx,
        output csr_commit_pc, csr_commit_badv, ws_flush,
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    // MEM stage / CSR unit / regfile side.
    modport slave (
        output ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
        output ms_exc_vec, ms_ertn, ms_badv, csr_commit_ack,
        input  ws_allowin, ws_rf_we, ws_rf_waddr, ws_rf_wdata,
        input  csr_commit_req, csr_commit_is_ertn, csr_commit_idx,
        input  csr_commit_pc, csr_commit_badv, ws_flush,
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

endinterface

// File: rtl/wb_commit_stage_exc_prio_enc.sv
// Highest-set-bit encoder for the exception vector, plus an any-set flag.
module exc_prio_enc #(
    parameter int unsigned EXC_W = 7,
    parameter int unsigned IDX_W = 3
) (
    input  logic [EXC_W-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_any_c
);

    // Ascending scan so the last hit (highest bit) wins; all-zero yields index 0.
    always_comb begin
        o_idx_c = '0;
        for (int i = 0; i < int'(EXC_W); i++) begin
            if (i_vec[i]) o_idx_c = IDX_W'(i);
        end
    end

    assign o_any_c = |i_vec;

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: retires MEM results and commits exceptions/ertn to the CSR unit.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned EXC_W  = 7,
    parameter int unsigned IDX_W  = 3
`ifdef WB_RETIRE_CNT_EN
   ,parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
`ifdef WB_RETIRE_CNT_EN
    output logic [CNT_W-1:0]   retire_cnt,
`endif
    wb_commit_stage_if.master  bus
);

    wb_state_e         r_state;
    wb_state_e         w_next_state;
    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [EXC_W-1:0]  r_exc_vec;
    logic              r_ertn;
    logic [PC_W-1:0]   r_badv;

    logic [IDX_W-1:0]  w_idx;
    logic              w_any_exc;
    logic              w_exc;
    logic              w_ready_go;
    logic              w_allowin;
    logic              w_load;
    logic              w_commit_req;
    logic              w_flush;
    logic              w_rf_we;

    exc_prio_enc #(
        .EXC_W (EXC_W),
        .IDX_W (IDX_W)
    ) u_exc_prio_enc (
        .i_vec   (r_exc_vec),
        .o_idx_c (w_idx),
        .o_any_c (w_any_exc)
    );

    assign w_exc      = r_valid & (w_any_exc | r_ertn);
    assign w_ready_go = ~w_exc;
    assign w_allowin  = ~r_valid | (w_ready_go & (r_state == ST_IDLE));
    assign w_load     = bus.ms_to_ws_valid & w_allowin;
    assign w_rf_we    = r_valid & r_rf_we & ~w_exc;

    // Commit FSM; ack is only consulted while the request is asserted.
    always_comb begin
        w_next_state = r_state;
        w_commit_req = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_exc) begin
                    w_commit_req = 1'b1;
                    w_next_state = bus.csr_commit_ack ? ST_FLUSH : ST_REQ;
                end
            end
            ST_REQ: begin
                w_commit_req = 1'b1;
                if (bus.csr_commit_ack) w_next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_flush      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // The committing instruction leaves at the end of FLUSH; MEM is being flushed so nothing loads.
    always_ff @(posedge clk) begin
        if (reset)                    r_valid <= 1'b0;
        else if (r_state == ST_FLUSH) r_valid <= 1'b0;
        else if (w_allowin)           r_valid <= bus.ms_to_ws_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_exc_vec  <= '0;
            r_ertn     <= 1'b0;
            r_badv     <= '0;
        end else if (w_load) begin
            r_pc       <= bus.ms_pc;
            r_rf_we    <= bus.ms_rf_we;
            r_rf_waddr <= bus.ms_rf_waddr;
            r_rf_wdata <= bus.ms_rf_wdata;
            r_exc_vec  <= bus.ms_exc_vec;
            r_ertn     <= bus.ms_ertn;
            r_badv     <= bus.ms_badv;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            retire_cnt <= '0;
        else if (r_valid & w_ready_go & (r_state == ST_IDLE))
            retire_cnt <= retire_cnt + CNT_W'(1);
    end
`endif

    assign bus.ws_allowin         = w_allowin;
    assign bus.ws_rf_we           = w_rf_we;
    assign bus.ws_rf_waddr        = r_rf_waddr;
    assign bus.ws_rf_wdata        = r_rf_wdata;
    assign bus.csr_commit_req     = w_commit_req;
    assign bus.csr_commit_is_ertn = r_ertn & ~w_any_exc;
    assign bus.csr_commit_idx     = w_idx;
    assign bus.csr_commit_pc      = r_pc;
    assign bus.csr_commit_badv    = r_badv;
    assign bus.ws_flush           = w_flush;
    assign bus.debug_wb_pc        = r_pc;
    assign bus.debug_wb_rf_we     = {4{w_rf_we}};
    assign bus.debug_wb_rf_wnum   = r_rf_waddr;
    assign bus.debug_wb_rf_wdata  = r_rf_wdata;

endmodule
